sc_buttonconditioner: RTL
=========================

Name: sc_buttonconditioner

Overview:
- Upstream conditioner for the Frogger game state machine.
- Takes the five raw, bouncing, active-low push-buttons: start, up, down, left, right.
- Produces synchronized, debounced active-low levels plus one-cycle active-low press pulses. The game FSM consumes these directly as its start/up/down/left/right button inputs.
- One independent debounce channel per button; no cross-button interaction.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable clocks required to accept a level change (20 ms at 50 MHz); legal range ≥ 2.
- CNT_WIDTH, 20, debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
- NUM_BUTTONS, 5, channel count; bit order [0]=start, [1]=up, [2]=down, [3]=left, [4]=right.

Ports:
- SC_STATEMACHINEGAME_CLOCK_50  input  1  system clock, 50 MHz.
- SC_STATEMACHINEGAME_RESET_InHigh  input  1  asynchronous, active-high reset.
- SC_BUTTONCONDITIONER_Raw_InLow  input  NUM_BUTTONS  raw asynchronous buttons, low = pressed.
- SC_BUTTONCONDITIONER_Level_OutLow  output  NUM_BUTTONS  debounced level, low = held.
- SC_BUTTONCONDITIONER_Press_OutLow  output  NUM_BUTTONS  one-cycle low pulse per accepted press.

Behaviour:
- Clock is SC_STATEMACHINEGAME_CLOCK_50; reset is SC_STATEMACHINEGAME_RESET_InHigh, asynchronous, active-high.
- Reset values:
  - Sync flops = all 1.
  - Counters = 0.
  - Per-channel state = RELEASED.
  - Level_OutLow = all 1; Press_OutLow = all 1.
- Synchronizer: 2-flop chain per bit; the debounce FSM sees only the second flop (s).
- Per-channel FSM, 2-bit state:
  - RELEASED: Level=1, counter=0. If s==0 → WAIT_PRESS, counter=1.
  - WAIT_PRESS: Level=1.
    - If s==1 → RELEASED, counter=0 (bounce rejected).
    - Else if counter==DEBOUNCE_CYCLES-1 → PRESSED, counter=0.
    - Else counter++.
  - PRESSED: Level=0. If s==1 → WAIT_RELEASE, counter=1.
  - WAIT_RELEASE: Level=0.
    - If s==0 → PRESSED, counter=0.
    - Else if counter==DEBOUNCE_CYCLES-1 → RELEASED, counter=0.
    - Else counter++.
- Outputs are registered: Level_OutLow[i] is a flop updated with the FSM.
- Press pulse:
  - Press_OutLow[i]=0 for exactly the one cycle in which Level_OutLow[i] first reads 0 after a RELEASED→PRESSED path; 1 otherwise.
  - No pulse on release.
- Latency, clean press:
  - Raw falls at edge k.
  - s falls at k+2.
  - Level and Press fall at k+2+DEBOUNCE_CYCLES.
  - Release is symmetric; Press stays 1 on release.
- Glitch shorter than DEBOUNCE_CYCLES clocks: no output change, no pulse.
- Bounce during WAIT_RELEASE that returns to PRESSED: no new pulse.
- Channels are fully independent. Simultaneous presses produce simultaneous pulses; any priority resolution belongs to the game FSM.
- Reset asserted mid-count or while held: all channels return to RELEASED immediately. After deassertion, a still-held button needs the full 2+DEBOUNCE_CYCLES and then produces one pulse.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap is possible.

Optional Feature:
- Macro: SC_BUTTONCONDITIONER_AUTOREPEAT_EN.
- Defined:
  - Adds parameters REPEAT_DELAY (default 25000000) and REPEAT_PERIOD (default 10000000), plus a per-channel repeat counter.
  - While in PRESSED, the counter counts from 0.
  - Extra one-cycle Press pulse at REPEAT_DELAY, then every REPEAT_PERIOD.
  - Counter clears on leaving PRESSED or on reset.
  - Level_OutLow is unaffected.
- Undefined: exactly one pulse per accepted press; no repeat logic synthesized.

Decomposition:
- Shared package sc_game_pkg:
  - Button index constants BTN_START=0, BTN_UP=1, BTN_DOWN=2, BTN_LEFT=3, BTN_RIGHT=4.
  - NUM_BUTTONS=5.
  - Debounce FSM state encoding (RELEASED=0, WAIT_PRESS=1, PRESSED=2, WAIT_RELEASE=3).
  - Default DEBOUNCE_CYCLES.
- Sub-module sc_buttondebounce_channel: synchronizer + FSM + counter + pulse (+ repeat when enabled) for one bit.
- Top instantiates NUM_BUTTONS channels via generate.

Test Plan (DEBOUNCE_CYCLES=8, CNT_WIDTH=4 for simulation):
- Clean press/release, up held low 20 cycles from cycle 10:
  - Level[1]=0 at cycle 20.
  - Press[1]=0 only at cycle 20.
  - Release at 30 → Level[1]=1 at 40; no release pulse.
- Bounce: start toggles 0/1 every 3 cycles for 30 cycles, then stays 1 → Level[0] and Press[0] remain 1 throughout.
- Release bounce: down held; 4-cycle high glitch at cycle 50 → Level[2] stays 0; no second pulse.
- Simultaneous: left and right fall at the same edge → both Press[3] and Press[4] pulse in the same cycle, 10 cycles later.
- Reset mid-operation: right held; assert reset at count 5 → outputs all 1 asynchronously. Deassert with button still held → pulse 10 cycles after deassertion.
- With SC_BUTTONCONDITIONER_AUTOREPEAT_EN, REPEAT_DELAY=16, REPEAT_PERIOD=4, up held 40 cycles after acceptance → pulses at acceptance and at +16, +20, +24, +28, +32, +36.

Source files
------------

// File: rtl/sc_game_pkg.sv
// Shared constants for the Frogger state machine game: button indices and the
// per-button debounce state encoding.
package sc_game_pkg;

  localparam int NUM_BUTTONS = 5;

  localparam int BTN_START = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_RIGHT = 4;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] WAIT_PRESS   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] WAIT_RELEASE = 2'd3;

  // Both held-side states drive the debounced level low.
  function automatic logic isHeld(input logic [1:0] state);
    return (state == PRESSED) || (state == WAIT_RELEASE);
  endfunction

endpackage

// File: rtl/sc_buttondebounce_channel.sv
// One button: 2-flop synchronizer, debounce FSM with stability counter, press pulse.
// Optional auto-repeat while held when SC_BUTTONCONDITIONER_AUTOREPEAT_EN is defined.
module sc_buttondebounce_channel
  import sc_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = 20
`ifdef SC_BUTTONCONDITIONER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic SC_STATEMACHINEGAME_CLOCK_50,
  input  logic SC_STATEMACHINEGAME_RESET_InHigh,
  input  logic rawLow,
  output logic levelLow,
  output logic pressLow
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 syncRaw_p0;
  logic                 syncRaw_p1;
  logic [1:0]           state;
  logic [1:0]           stateNxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cntNxt;
  logic                 acceptPulse;
  logic                 rptFire;

  always_comb begin
    stateNxt    = state;
    cntNxt      = cnt;
    acceptPulse = 1'b0;
    case (state)
      RELEASED: begin
        if (!syncRaw_p1) begin
          stateNxt = WAIT_PRESS;
          cntNxt   = CNT_WIDTH'(1);
        end
      end
      WAIT_PRESS: begin
        if (syncRaw_p1) begin
          stateNxt = RELEASED;
          cntNxt   = '0;
        end else if (cnt == CNT_LAST) begin
          stateNxt    = PRESSED;
          cntNxt      = '0;
          acceptPulse = 1'b1;
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (syncRaw_p1) begin
          stateNxt = WAIT_RELEASE;
          cntNxt   = CNT_WIDTH'(1);
        end
      end
      default: begin
        // A bounce back to low returns to PRESSED without a new pulse.
        if (!syncRaw_p1) begin
          stateNxt = PRESSED;
          cntNxt   = '0;
        end else if (cnt == CNT_LAST) begin
          stateNxt = RELEASED;
          cntNxt   = '0;
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
    endcase
  end

`ifdef SC_BUTTONCONDITIONER_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rptCnt;
  logic             stayPressed;

  assign stayPressed = (state == PRESSED) && (stateNxt == PRESSED);
  assign rptFire     = stayPressed && (rptCnt == RPT_LAST);

  // Reloading below the delay makes later repeats land every REPEAT_PERIOD.
  always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or posedge SC_STATEMACHINEGAME_RESET_InHigh) begin
    if (SC_STATEMACHINEGAME_RESET_InHigh) begin
      rptCnt <= '0;
    end else if (!stayPressed) begin
      rptCnt <= '0;
    end else if (rptFire) begin
      rptCnt <= RPT_RELOAD;
    end else begin
      rptCnt <= rptCnt + 1'b1;
    end
  end
`else
  assign rptFire = 1'b0;
`endif

  // Synchronizer stages, then FSM and registered outputs.
  always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or posedge SC_STATEMACHINEGAME_RESET_InHigh) begin
    if (SC_STATEMACHINEGAME_RESET_InHigh) begin
      syncRaw_p0 <= 1'b1;
      syncRaw_p1 <= 1'b1;
      state      <= RELEASED;
      cnt        <= '0;
      levelLow   <= 1'b1;
      pressLow   <= 1'b1;
    end else begin
      syncRaw_p0 <= rawLow;
      syncRaw_p1 <= syncRaw_p0;
      state      <= stateNxt;
      cnt        <= cntNxt;
      levelLow   <= ~isHeld(stateNxt);
      pressLow   <= ~(acceptPulse | rptFire);
    end
  end

endmodule

// File: rtl/sc_buttonconditioner.sv
// Conditions the five raw active-low game buttons into debounced levels and press pulses.
// Optional auto-repeat is enabled by defining SC_BUTTONCONDITIONER_AUTOREPEAT_EN.
module sc_buttonconditioner #(
  parameter int DEBOUNCE_CYCLES = sc_game_pkg::DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = 20,
  parameter int NUM_BUTTONS     = sc_game_pkg::NUM_BUTTONS
`ifdef SC_BUTTONCONDITIONER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic                   SC_STATEMACHINEGAME_CLOCK_50,
  input  logic                   SC_STATEMACHINEGAME_RESET_InHigh,
  input  logic [NUM_BUTTONS-1:0] SC_BUTTONCONDITIONER_Raw_InLow,
  output logic [NUM_BUTTONS-1:0] SC_BUTTONCONDITIONER_Level_OutLow,
  output logic [NUM_BUTTONS-1:0] SC_BUTTONCONDITIONER_Press_OutLow
);

  import sc_game_pkg::*;

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : gChannel
    sc_buttondebounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
`ifdef SC_BUTTONCONDITIONER_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) uChannel (
      .SC_STATEMACHINEGAME_CLOCK_50    (SC_STATEMACHINEGAME_CLOCK_50),
      .SC_STATEMACHINEGAME_RESET_InHigh(SC_STATEMACHINEGAME_RESET_InHigh),
      .rawLow                          (SC_BUTTONCONDITIONER_Raw_InLow[gi]),
      .levelLow                        (SC_BUTTONCONDITIONER_Level_OutLow[gi]),
      .pressLow                        (SC_BUTTONCONDITIONER_Press_OutLow[gi])
    );
  end

endmodule
